ftb_update_scheduler: RTL and testbench

- Shares the single-port FTB SRAM between per-cycle BPU prediction queries and FTQ-originated training writes.
- Buffers training updates in a small in-order queue and coalesces back-to-back updates to the same PC.
- Grants the SRAM port to queries by default; inserts a write, stalling the BPU, when the queue is full or a write has starved too long.
- Sits between the FTQ training path, the BPU query path and the FTB's update port.

---
 rtl/ftb_update_scheduler.sv | 124 ++++++++++++
 tb/tb_ftb_update_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftb_update_scheduler.sv
// FTB update scheduler: arbitrates the single-port FTB SRAM between BPU reads
// and queued, coalesced FTQ training writes.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   query_valid_i            BPU wants an FTB read this cycle
//   query_stall_o            BPU read denied (a write took the port)
//   ftb_re_o                 FTB read enable
//   train_valid_i/ready_o    training update handshake
//   train_pc_i/entry_i       training update payload
//   ftb_we_o/wpc_o/wentry_o  FTB write port (head of queue)
//   occupancy_o              registered queue count
//   perf_forced_write_o      pulse when a write stalled a query
module ftb_update_scheduler #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ENTRY_WIDTH  = 64,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           query_valid_i,
    output logic                           query_stall_o,
    output logic                           ftb_re_o,
    input  logic                           train_valid_i,
    output logic                           train_ready_o,
    input  logic [ADDR_WIDTH-1:0]          train_pc_i,
    input  logic [ENTRY_WIDTH-1:0]         train_entry_i,
    output logic                           ftb_we_o,
    output logic [ADDR_WIDTH-1:0]          ftb_wpc_o,
    output logic [ENTRY_WIDTH-1:0]         ftb_wentry_o,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy_o,
    output logic                           perf_forced_write_o
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
    localparam logic [SW-1:0] SAT  = SW'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0]  pc_q    [QUEUE_DEPTH];
    logic [ENTRY_WIDTH-1:0] entry_q [QUEUE_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_last;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [SW-1:0] starve_cnt;

    logic force_write;
    logic write_grant;
    logic push;
    logic coalesce;
    logic do_push;

    assign tail_last   = tail - PW'(1);
    assign force_write = (count == FULL) | (starve_cnt == SAT);

    // No write may issue while reset is asserted, even if stale state
    // still holds entries.
    assign write_grant = rst & (count != '0)
                       & (~query_valid_i | force_write);

    assign train_ready_o = ~rst | (count != FULL);
    assign push          = train_valid_i & train_ready_o;

    // Merge into the newest entry unless that entry is the one leaving
    // this cycle (sole entry being written).
    assign coalesce = push & (count != '0)
                    & (pc_q[tail_last] == train_pc_i)
                    & ~(write_grant & (count == CW'(1)));
    assign do_push  = push & ~coalesce;

    assign ftb_we_o            = write_grant;
    assign ftb_wpc_o           = write_grant ? pc_q[head] : '0;
    assign ftb_wentry_o        = write_grant ? entry_q[head] : '0;
    assign ftb_re_o            = query_valid_i & ~write_grant;
    assign query_stall_o       = query_valid_i & write_grant;
    assign perf_forced_write_o = query_stall_o;
    assign occupancy_o         = count;

    always_comb begin
        count_next = count;
        unique case ({do_push, write_grant})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            count <= count_next;
            if (do_push)
                tail <= tail + PW'(1);
            if (write_grant)
                head <= head + PW'(1);
            if ((count == '0) | write_grant)
                starve_cnt <= '0;
            else if (starve_cnt != SAT)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Storage needs no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (coalesce)
                entry_q[tail_last] <= train_entry_i;
            if (do_push) begin
                pc_q[tail]    <= train_pc_i;
                entry_q[tail] <= train_entry_i;
            end
        end
    end

endmodule

// File: tb/tb_ftb_update_scheduler.sv
// Directed self-checking bench for ftb_update_scheduler.
// Default parameters: depth 4, starve limit 8.
module tb_ftb_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        query_valid_i;
    logic        query_stall_o;
    logic        ftb_re_o;
    logic        train_valid_i;
    logic        train_ready_o;
    logic [31:0] train_pc_i;
    logic [63:0] train_entry_i;
    logic        ftb_we_o;
    logic [31:0] ftb_wpc_o;
    logic [63:0] ftb_wentry_o;
    logic [2:0]  occupancy_o;
    logic        perf_forced_write_o;

    int checks = 0;
    int errors = 0;

    ftb_update_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .query_valid_i       (query_valid_i),
        .query_stall_o       (query_stall_o),
        .ftb_re_o            (ftb_re_o),
        .train_valid_i       (train_valid_i),
        .train_ready_o       (train_ready_o),
        .train_pc_i          (train_pc_i),
        .train_entry_i       (train_entry_i),
        .ftb_we_o            (ftb_we_o),
        .ftb_wpc_o           (ftb_wpc_o),
        .ftb_wentry_o        (ftb_wentry_o),
        .occupancy_o         (occupancy_o),
        .perf_forced_write_o (perf_forced_write_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        query_valid_i = 1'b1;
        train_valid_i = 1'b0;
        train_pc_i = '0;
        train_entry_i = '0;
        tick();
        tick();
        #1;
        checks++;
        if (ftb_re_o !== 1'b1) begin
            errors++; $display("FAIL reset_re got %b exp 1", ftb_re_o);
        end
        checks++;
        if (ftb_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_we got %b exp 0", ftb_we_o);
        end
        checks++;
        if (train_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", train_ready_o);
        end
        checks++;
        if (occupancy_o !== 3'd0) begin
            errors++; $display("FAIL reset_occ got %0d exp 0", occupancy_o);
        end
        checks++;
        if (query_stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", query_stall_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        query_valid_i = 1'b0;
        train_valid_i = 1'b1;
        train_pc_i = 32'h1c00_0000;
        train_entry_i = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if (ftb_we_o !== 1'b0) begin
            errors++; $display("FAIL single_c0_we got %b exp 0", ftb_we_o);
        end
        tick();
        train_valid_i = 1'b0;
        #1;
        checks++;
        if (ftb_we_o !== 1'b1 || ftb_wpc_o !== 32'h1c00_0000) begin
            errors++;
            $display("FAIL single_c1_write we %b pc %h exp 1 1c000000",
                     ftb_we_o, ftb_wpc_o);
        end
        checks++;
        if (ftb_wentry_o !== 64'h1111_2222_3333_4444) begin
            errors++; $display("FAIL single_c1_entry got %h", ftb_wentry_o);
        end
        checks++;
        if (occupancy_o !== 3'd1) begin
            errors++; $display("FAIL single_c1_occ got %0d exp 1", occupancy_o);
        end
        tick();
        checks++;
        if (occupancy_o !== 3'd0 || ftb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_c2 occ %0d we %b exp 0 0", occupancy_o, ftb_we_o);
        end
    endtask

    task automatic test_starve();
        query_valid_i = 1'b1;
        train_valid_i = 1'b1;
        train_pc_i = 32'h1c00_0100;
        train_entry_i = 64'hdead_beef_0000_0001;
        tick();
        train_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            checks++;
            if (ftb_we_o !== 1'b0 || ftb_re_o !== 1'b1) begin
                errors++;
                $display("FAIL starve_c%0d we %b re %b exp 0 1", c, ftb_we_o, ftb_re_o);
            end
            tick();
        end
        #1;
        checks++;
        if (ftb_we_o !== 1'b1 || query_stall_o !== 1'b1 || perf_forced_write_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_c9 we %b stall %b perf %b exp 1 1 1",
                     ftb_we_o, query_stall_o, perf_forced_write_o);
        end
        checks++;
        if (ftb_re_o !== 1'b0 || ftb_wpc_o !== 32'h1c00_0100) begin
            errors++;
            $display("FAIL starve_c9_port re %b pc %h exp 0 1c000100", ftb_re_o, ftb_wpc_o);
        end
        tick();
        #1;
        checks++;
        if (ftb_re_o !== 1'b1 || ftb_we_o !== 1'b0 || occupancy_o !== 3'd0) begin
            errors++;
            $display("FAIL starve_c10 re %b we %b occ %0d exp 1 0 0",
                     ftb_re_o, ftb_we_o, occupancy_o);
        end
    endtask

    task automatic test_full();
        logic [31:0] pcs [4];
        for (int i = 0; i < 4; i++)
            pcs[i] = 32'h1c00_1000 + 32'(i * 32'h20);
        query_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            train_valid_i = 1'b1;
            train_pc_i = pcs[i];
            train_entry_i = {32'hf00d_0000, 32'(i)};
            #1;
            checks++;
            if (train_ready_o !== 1'b1 || ftb_we_o !== 1'b0) begin
                errors++;
                $display("FAIL full_push%0d ready %b we %b exp 1 0", i, train_ready_o, ftb_we_o);
            end
            tick();
        end
        train_valid_i = 1'b0;
        #1;
        checks++;
        if (train_ready_o !== 1'b0 || occupancy_o !== 3'd4) begin
            errors++;
            $display("FAIL full_state ready %b occ %0d exp 0 4", train_ready_o, occupancy_o);
        end
        checks++;
        if (ftb_we_o !== 1'b1 || query_stall_o !== 1'b1 || ftb_wpc_o !== pcs[0]) begin
            errors++;
            $display("FAIL full_force we %b stall %b pc %h exp 1 1 %h",
                     ftb_we_o, query_stall_o, ftb_wpc_o, pcs[0]);
        end
        tick();
        #1;
        checks++;
        if (train_ready_o !== 1'b1 || occupancy_o !== 3'd3 || ftb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL full_recover ready %b occ %0d we %b exp 1 3 0",
                     train_ready_o, occupancy_o, ftb_we_o);
        end
        query_valid_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            checks++;
            if (ftb_we_o !== 1'b1 || ftb_wpc_o !== pcs[i]
                || ftb_wentry_o !== {32'hf00d_0000, 32'(i)}) begin
                errors++;
                $display("FAIL full_drain%0d we %b pc %h exp 1 %h", i, ftb_we_o, ftb_wpc_o, pcs[i]);
            end
            tick();
        end
        checks++;
        if (occupancy_o !== 3'd0) begin
            errors++; $display("FAIL full_empty got %0d exp 0", occupancy_o);
        end
    endtask

    task automatic test_coalesce();
        query_valid_i = 1'b1;
        train_valid_i = 1'b1;
        train_pc_i = 32'h1c00_0010;
        train_entry_i = 64'haaaa_aaaa_aaaa_aaaa;
        tick();
        train_entry_i = 64'hbbbb_bbbb_bbbb_bbbb;
        #1;
        checks++;
        if (ftb_we_o !== 1'b0) begin
            errors++; $display("FAIL coal_c1_we got %b exp 0", ftb_we_o);
        end
        tick();
        train_valid_i = 1'b0;
        #1;
        checks++;
        if (occupancy_o !== 3'd1) begin
            errors++; $display("FAIL coal_occ got %0d exp 1", occupancy_o);
        end
        query_valid_i = 1'b0;
        #1;
        checks++;
        if (ftb_we_o !== 1'b1 || ftb_wpc_o !== 32'h1c00_0010
            || ftb_wentry_o !== 64'hbbbb_bbbb_bbbb_bbbb) begin
            errors++;
            $display("FAIL coal_write we %b pc %h entry %h exp 1 1c000010 bbbb..",
                     ftb_we_o, ftb_wpc_o, ftb_wentry_o);
        end
        tick();
        checks++;
        if (occupancy_o !== 3'd0 || ftb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL coal_done occ %0d we %b exp 0 0", occupancy_o, ftb_we_o);
        end
    endtask

    task automatic test_coalesce_pop();
        query_valid_i = 1'b0;
        train_valid_i = 1'b1;
        train_pc_i = 32'h1c00_0010;
        train_entry_i = 64'haaaa_aaaa_aaaa_aaaa;
        tick();
        train_entry_i = 64'hbbbb_bbbb_bbbb_bbbb;
        #1;
        checks++;
        if (ftb_we_o !== 1'b1 || ftb_wentry_o !== 64'haaaa_aaaa_aaaa_aaaa) begin
            errors++;
            $display("FAIL cpop_first we %b entry %h exp 1 aaaa..", ftb_we_o, ftb_wentry_o);
        end
        tick();
        train_valid_i = 1'b0;
        #1;
        checks++;
        if (occupancy_o !== 3'd1 || ftb_we_o !== 1'b1
            || ftb_wentry_o !== 64'hbbbb_bbbb_bbbb_bbbb) begin
            errors++;
            $display("FAIL cpop_second occ %0d we %b entry %h exp 1 1 bbbb..",
                     occupancy_o, ftb_we_o, ftb_wentry_o);
        end
        tick();
        checks++;
        if (occupancy_o !== 3'd0) begin
            errors++; $display("FAIL cpop_empty got %0d exp 0", occupancy_o);
        end
    endtask

    task automatic test_back_to_back();
        query_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            train_valid_i = 1'b1;
            train_pc_i = 32'h1c00_2000 + 32'(i * 32'h40);
            train_entry_i = {32'h0b2b_0000, 32'(i)};
            #1;
            if (i > 0) begin
                checks++;
                if (occupancy_o !== 3'd1 || ftb_we_o !== 1'b1
                    || ftb_wpc_o !== 32'h1c00_2000 + 32'((i - 1) * 32'h40)) begin
                    errors++;
                    $display("FAIL b2b_c%0d occ %0d we %b pc %h", i, occupancy_o, ftb_we_o, ftb_wpc_o);
                end
            end
            tick();
        end
        train_valid_i = 1'b0;
        #1;
        checks++;
        if (occupancy_o !== 3'd1 || ftb_wpc_o !== 32'h1c00_2080) begin
            errors++;
            $display("FAIL b2b_last occ %0d pc %h exp 1 1c002080", occupancy_o, ftb_wpc_o);
        end
        tick();
    endtask

    task automatic test_reset_flush();
        query_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            train_valid_i = 1'b1;
            train_pc_i = 32'h1c00_3000 + 32'(i * 32'h20);
            train_entry_i = 64'(i) + 64'h5;
            tick();
        end
        train_valid_i = 1'b0;
        #1;
        checks++;
        if (occupancy_o !== 3'd3) begin
            errors++; $display("FAIL flush_pre_occ got %0d exp 3", occupancy_o);
        end
        rst = 1'b0;
        query_valid_i = 1'b0;
        #1;
        checks++;
        if (ftb_we_o !== 1'b0 || train_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_rst_cycle we %b ready %b exp 0 1", ftb_we_o, train_ready_o);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (occupancy_o !== 3'd0) begin
            errors++; $display("FAIL flush_occ got %0d exp 0", occupancy_o);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (ftb_we_o !== 1'b0) begin
                errors++; $display("FAIL flush_nowrite%0d got %b exp 0", c, ftb_we_o);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_starve();
        test_full();
        test_coalesce();
        test_coalesce_pop();
        test_back_to_back();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
